// File: rtl/ray_pkg.sv
// Shared ray-caster constants, column buffer entry type and colour helpers.
// Imported by the column renderer and its column RAM.
package ray_pkg;

  localparam int NUM_COLUMNS = 175;
  localparam int HALF_V_RES  = 300;
  localparam int HEIGHT_W    = 10;
  localparam int COL_W       = 10;
  localparam int SHADE_W     = 2;
  localparam int RGB_W       = 12;
  localparam int DEPTH       = 2 * NUM_COLUMNS;
  localparam int ADDR_W      = 9;

  localparam logic [RGB_W-1:0]    CEIL_RGB  = 12'h446;
  localparam logic [RGB_W-1:0]    FLOOR_RGB = 12'h642;
  localparam logic                SYNC_RST  = 1'b1;
  localparam logic [HEIGHT_W-1:0] MAX_H     = HEIGHT_W'(2 * HALF_V_RES);

  typedef struct packed {
    logic [SHADE_W-1:0]  shade;
    logic [HEIGHT_W-1:0] height;
  } col_entry_t;

  typedef enum logic {
    IDLE_FILL,
    PENDING
  } swap_state_t;

  function automatic logic [RGB_W-1:0] shade_rgb(
    input logic [SHADE_W-1:0] s
  );
    logic [3:0] c;
    c = 4'hF >> s;
    return {c, c, c};
  endfunction

  // Bank 1 sits directly above bank 0 in the flat RAM.
  function automatic logic [ADDR_W-1:0] col_addr(
    input logic             bank,
    input logic [COL_W-1:0] col
  );
    logic [ADDR_W-1:0] base;
    base = bank ? ADDR_W'(NUM_COLUMNS) : '0;
    return base + col[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/column_ram.sv
// Simple dual-port column buffer, both banks in one array.
// Synchronous write and 1-cycle registered read.
module column_ram
  import ray_pkg::*;
(
  input  logic              half_clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  col_entry_t        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output col_entry_t        rdata_o
);

  col_entry_t mem_q [DEPTH];

  always_ff @(posedge half_clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/wall_column_renderer.sv
// Ping-pong wall column buffer with vsync-aligned bank swap.
// Two-stage pixel pipeline turning timing into 12-bit RGB.
module wall_column_renderer
  import ray_pkg::*;
(
  input  logic                half_clk,
  input  logic                rst_n,
  input  logic                visible_area,
  input  logic                active_area,
  input  logic                hsync,
  input  logic                vsync,
  input  logic                is_ceiling,
  input  logic [COL_W-1:0]    line_number,
  input  logic [HEIGHT_W-1:0] active_area_height,
  input  logic                col_valid,
  output logic                col_ready,
  input  logic [COL_W-1:0]    col_index,
  input  logic [HEIGHT_W-1:0] col_height,
  input  logic [SHADE_W-1:0]  col_shade,
  input  logic                frame_done,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic [3:0]          red,
  output logic [3:0]          green,
  output logic [3:0]          blue,
  output logic                swap_pending,
  output logic                err_overrun,
  output logic                err_range
);

  swap_state_t state_q;
  logic        rd_bank_q;
  logic        wr_bank_q;
  logic [1:0]  bank_valid_q;
  logic        col_ready_q;
  logic        err_overrun_q;
  logic        err_range_q;

  logic                vis_q;
  logic                act_q;
  logic                ceil_q;
  logic [HEIGHT_W-1:0] aah_q;
  logic                oor_q;
  logic                bv_q;
  logic                hs_q;
  logic                vs_q;
  logic [RGB_W-1:0]    rgb_q;
  logic                hsync_q;
  logic                vsync_q;

  logic              accept;
  logic              in_range;
  logic              vs_edge;
  logic              ln_oor;
  logic [ADDR_W-1:0] raddr;
  col_entry_t        rdata;

  assign accept   = col_valid && col_ready_q;
  assign in_range = col_index < COL_W'(NUM_COLUMNS);
  assign vs_edge  = vsync != vs_q;
  assign ln_oor   = line_number >= COL_W'(NUM_COLUMNS);
  assign raddr    = col_addr(rd_bank_q, ln_oor ? '0 : line_number);

  column_ram u_ram (
    .half_clk (half_clk),
    .we_i     (accept && in_range),
    .waddr_i  (col_addr(wr_bank_q, col_index)),
    .wdata_i  ({col_shade, col_height}),
    .raddr_i  (raddr),
    .rdata_o  (rdata)
  );

  always_ff @(posedge half_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE_FILL;
      rd_bank_q     <= 1'b0;
      wr_bank_q     <= 1'b1;
      bank_valid_q  <= 2'b00;
      col_ready_q   <= 1'b1;
      err_overrun_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      if (accept && !in_range) begin
        err_range_q <= 1'b1;
      end
      unique case (state_q)
        IDLE_FILL: begin
          if (frame_done) begin
            state_q     <= PENDING;
            col_ready_q <= 1'b0;
          end
        end
        PENDING: begin
          if (frame_done) begin
            err_overrun_q <= 1'b1;
          end
          if (vs_edge) begin
            state_q                 <= IDLE_FILL;
            col_ready_q             <= 1'b1;
            rd_bank_q               <= wr_bank_q;
            wr_bank_q               <= rd_bank_q;
            bank_valid_q[wr_bank_q] <= 1'b1;
          end
        end
        default: state_q <= IDLE_FILL;
      endcase
    end
  end

  always_ff @(posedge half_clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_q  <= 1'b0;
      act_q  <= 1'b0;
      ceil_q <= 1'b0;
      aah_q  <= '0;
      oor_q  <= 1'b0;
      bv_q   <= 1'b0;
      hs_q   <= SYNC_RST;
      vs_q   <= SYNC_RST;
    end else begin
      vis_q  <= visible_area;
      act_q  <= active_area;
      ceil_q <= is_ceiling;
      aah_q  <= active_area_height;
      oor_q  <= ln_oor;
      bv_q   <= bank_valid_q[rd_bank_q];
      hs_q   <= hsync;
      vs_q   <= vsync;
    end
  end

  logic [HEIGHT_W-1:0] h_s1;
  logic [HEIGHT_W:0]   sum_s1;
  logic                wall_s1;
  logic [RGB_W-1:0]    rgb_d;

  // Sum is one bit wider than the height so tall walls never wrap.
  always_comb begin
    h_s1 = '0;
    if (bv_q && !oor_q) begin
      h_s1 = (rdata.height > MAX_H) ? MAX_H : rdata.height;
    end
    sum_s1  = {1'b0, aah_q} + {2'b00, h_s1[HEIGHT_W-1:1]};
    wall_s1 = sum_s1 >= (HEIGHT_W+1)'(HALF_V_RES);
  end

  always_comb begin
    rgb_d = '0;
    unique case (1'b1)
      !vis_q:                     rgb_d = '0;
      vis_q && !act_q:            rgb_d = '0;
      vis_q && act_q && wall_s1:  rgb_d = shade_rgb(rdata.shade);
      vis_q && act_q && !wall_s1: rgb_d = ceil_q ? CEIL_RGB : FLOOR_RGB;
      default:                    rgb_d = '0;
    endcase
  end

  always_ff @(posedge half_clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      hsync_q <= SYNC_RST;
      vsync_q <= SYNC_RST;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hs_q;
      vsync_q <= vs_q;
    end
  end

  assign col_ready    = col_ready_q;
  assign swap_pending = state_q == PENDING;
  assign err_overrun  = err_overrun_q;
  assign err_range    = err_range_q;
  assign hsync_out    = hsync_q;
  assign vsync_out    = vsync_q;
  assign red          = rgb_q[11:8];
  assign green        = rgb_q[7:4];
  assign blue         = rgb_q[3:0];

endmodule
